// File: rtl/bcd_mod_cnt.sv
// Two-digit BCD modulo counter with load/range check, adjust step and ripple carry.
// Optional down-counting and borrow logic are enabled by defining BCDCNT_DOWNCNT_EN.
module bcd_mod_cnt #(
  parameter int unsigned MAX_TENS = 5,
  parameter int unsigned MAX_ONES = 9,
  parameter int unsigned MIN_TENS = 0,
  parameter int unsigned MIN_ONES = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       enin,
  input  logic       dn,
  input  logic       adj,
  input  logic       ld,
  input  logic [3:0] ld_tens,
  input  logic [3:0] ld_ones,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       enout,
  output logic       at_max,
  output logic       at_min,
  output logic       ld_err
);

  localparam logic [3:0] MAXT = 4'(MAX_TENS);
  localparam logic [3:0] MAXO = 4'(MAX_ONES);
  localparam logic [3:0] MINT = 4'(MIN_TENS);
  localparam logic [3:0] MINO = 4'(MIN_ONES);
  localparam logic signed [8:0] MAX_S = 9'(MAX_TENS * 10 + MAX_ONES);
  localparam logic signed [8:0] MIN_S = 9'(MIN_TENS * 10 + MIN_ONES);

  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic       ld_err_q, ld_err_d;

  logic [3:0] up_t, up_o;
  logic [3:0] nx_t, nx_o;
  logic       terminal;
  logic       ld_ok;
  logic signed [8:0] ld_val;

  // Signed decimal value of a BCD pair, so range checks against a zero bound stay meaningful.
  function automatic logic signed [8:0] bcd_value(input logic [3:0] t, input logic [3:0] o);
    return signed'({1'b0, 8'(t) * 8'd10 + 8'(o)});
  endfunction

  assign at_max = (tens_q == MAXT) && (ones_q == MAXO);
  assign at_min = (tens_q == MINT) && (ones_q == MINO);

  assign ld_val = bcd_value(ld_tens, ld_ones);
  assign ld_ok  = (ld_tens <= 4'd9) && (ld_ones <= 4'd9) &&
                  (ld_val >= MIN_S) && (ld_val <= MAX_S);

  always_comb begin
    up_t = tens_q;
    up_o = ones_q;
    if (at_max) begin
      up_t = MINT;
      up_o = MINO;
    end else if (ones_q == 4'd9) begin
      up_t = tens_q + 4'd1;
      up_o = 4'd0;
    end else begin
      up_o = ones_q + 4'd1;
    end
  end

`ifdef BCDCNT_DOWNCNT_EN
  logic [3:0] dn_t, dn_o;

  always_comb begin
    dn_t = tens_q;
    dn_o = ones_q;
    if (at_min) begin
      dn_t = MAXT;
      dn_o = MAXO;
    end else if (ones_q == 4'd0) begin
      dn_t = tens_q - 4'd1;
      dn_o = 4'd9;
    end else begin
      dn_o = ones_q - 4'd1;
    end
  end

  assign nx_t     = dn ? dn_t : up_t;
  assign nx_o     = dn ? dn_o : up_o;
  assign terminal = dn ? at_min : at_max;
`else
  logic unused_dn;

  assign unused_dn = dn;
  assign nx_t      = up_t;
  assign nx_o      = up_o;
  assign terminal  = at_max;
`endif

  // Priority: clr > ld > adj > enin; rst is handled in the register itself.
  always_comb begin
    tens_d   = tens_q;
    ones_d   = ones_q;
    ld_err_d = 1'b0;
    if (clr) begin
      tens_d = MINT;
      ones_d = MINO;
    end else if (ld) begin
      if (ld_ok) begin
        tens_d = ld_tens;
        ones_d = ld_ones;
      end else begin
        ld_err_d = 1'b1;
      end
    end else if (adj || enin) begin
      tens_d = nx_t;
      ones_d = nx_o;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tens_q   <= MINT;
      ones_q   <= MINO;
      ld_err_q <= 1'b0;
    end else begin
      tens_q   <= tens_d;
      ones_q   <= ones_d;
      ld_err_q <= ld_err_d;
    end
  end

  // Zero-latency carry so a chain of instances ripples within one cycle.
  assign enout  = enin & ~rst & ~clr & ~ld & ~adj & terminal;
  assign tens   = tens_q;
  assign ones   = ones_q;
  assign ld_err = ld_err_q;

endmodule

// File: tb/tb_bcd_mod_cnt.sv
// Self-checking bench for bcd_mod_cnt: four differently ranged instances share stimulus
// and are compared every cycle against a decimal-arithmetic model.
module tb_bcd_mod_cnt;

`ifdef BCDCNT_DOWNCNT_EN
  localparam bit DOWN = 1'b1;
`else
  localparam bit DOWN = 1'b0;
`endif

  localparam int MAXV[4] = '{59, 23, 12, 7};
  localparam int MINV[4] = '{0, 0, 1, 7};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, clr, enin, dn, adj, ld;
  logic [3:0] lt, lo;
  logic [3:0] t_o[4];
  logic [3:0] o_o[4];
  logic       eo[4], amx[4], amn[4], le[4];

  bcd_mod_cnt #(.MAX_TENS(5), .MAX_ONES(9), .MIN_TENS(0), .MIN_ONES(0)) u0 (
    .clk(clk), .rst(rst), .clr(clr), .enin(enin), .dn(dn), .adj(adj), .ld(ld),
    .ld_tens(lt), .ld_ones(lo), .tens(t_o[0]), .ones(o_o[0]), .enout(eo[0]),
    .at_max(amx[0]), .at_min(amn[0]), .ld_err(le[0]));
  bcd_mod_cnt #(.MAX_TENS(2), .MAX_ONES(3), .MIN_TENS(0), .MIN_ONES(0)) u1 (
    .clk(clk), .rst(rst), .clr(clr), .enin(enin), .dn(dn), .adj(adj), .ld(ld),
    .ld_tens(lt), .ld_ones(lo), .tens(t_o[1]), .ones(o_o[1]), .enout(eo[1]),
    .at_max(amx[1]), .at_min(amn[1]), .ld_err(le[1]));
  bcd_mod_cnt #(.MAX_TENS(1), .MAX_ONES(2), .MIN_TENS(0), .MIN_ONES(1)) u2 (
    .clk(clk), .rst(rst), .clr(clr), .enin(enin), .dn(dn), .adj(adj), .ld(ld),
    .ld_tens(lt), .ld_ones(lo), .tens(t_o[2]), .ones(o_o[2]), .enout(eo[2]),
    .at_max(amx[2]), .at_min(amn[2]), .ld_err(le[2]));
  bcd_mod_cnt #(.MAX_TENS(0), .MAX_ONES(7), .MIN_TENS(0), .MIN_ONES(7)) u3 (
    .clk(clk), .rst(rst), .clr(clr), .enin(enin), .dn(dn), .adj(adj), .ld(ld),
    .ld_tens(lt), .ld_ones(lo), .tens(t_o[3]), .ones(o_o[3]), .enout(eo[3]),
    .at_max(amx[3]), .at_min(amn[3]), .ld_err(le[3]));

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  int mv[4];
  bit me[4];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: the counter value as a plain decimal number in [MIN,MAX].
  function automatic int step(input int k, input int v, input bit d);
    if (DOWN && d) return (v == MINV[k]) ? MAXV[k] : v - 1;
    return (v == MAXV[k]) ? MINV[k] : v + 1;
  endfunction

  function automatic bit term(input int k, input int v, input bit d);
    if (DOWN && d) return v == MINV[k];
    return v == MAXV[k];
  endfunction

  function automatic bit load_ok(input int k);
    int dv;
    dv = int'(lt) * 10 + int'(lo);
    return (lt <= 9) && (lo <= 9) && (dv >= MINV[k]) && (dv <= MAXV[k]);
  endfunction

  function automatic int next_val(input int k, input int v);
    if (rst || clr) return MINV[k];
    if (ld) return load_ok(k) ? int'(lt) * 10 + int'(lo) : v;
    if (adj || enin) return step(k, v, dn);
    return v;
  endfunction

  function automatic bit next_err(input int k);
    return !(rst || clr) && ld && !load_ok(k);
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      mv[k] <= next_val(k, mv[k]);
      me[k] <= next_err(k);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("u%0d tens", k), int'(t_o[k]), mv[k] / 10);
        chk($sformatf("u%0d ones", k), int'(o_o[k]), mv[k] % 10);
        chk($sformatf("u%0d at_max", k), int'(amx[k]), int'(mv[k] == MAXV[k]));
        chk($sformatf("u%0d at_min", k), int'(amn[k]), int'(mv[k] == MINV[k]));
        chk($sformatf("u%0d ld_err", k), int'(le[k]), int'(me[k]));
        chk($sformatf("u%0d enout", k), int'(eo[k]),
            int'(enin && !rst && !clr && !ld && !adj && term(k, mv[k], dn)));
      end
    end
  end

  task automatic cyc(input bit e, input bit d, input bit a, input bit l,
                     input int t, input int o, input bit r = 1'b0, input bit c = 1'b0);
    @(posedge clk);
    #1;
    enin = e; dn = d; adj = a; ld = l;
    lt = 4'(t); lo = 4'(o);
    rst = r; clr = c;
  endtask

  function automatic int val(input int k);
    return int'(t_o[k]) * 10 + int'(o_o[k]);
  endfunction

  initial begin
    rst = 1'b1; clr = 1'b0; enin = 1'b0; dn = 1'b0; adj = 1'b0; ld = 1'b0;
    lt = 4'd0; lo = 4'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    #1;
    chk("reset u0", val(0), 0);
    chk("reset u1", val(1), 0);
    chk("reset u2", val(2), 1);
    chk("reset u3", val(3), 7);
    chk("reset ld_err", int'(le[0]), 0);

    // Sixty ticks through the default 00..59 range.
    for (int i = 1; i <= 60; i++) begin
      cyc(1, 0, 0, 0, 0, 0);
      #1;
      if (i == 1)  chk("single-range enout", int'(eo[3]), 1);
      if (i == 30) chk("mid-count enout", int'(eo[0]), 0);
      if (i == 30) chk("mid-count value", val(0), 29);
      if (i == 60) begin
        chk("59 value", val(0), 59);
        chk("59 at_max", int'(amx[0]), 1);
        chk("59 enout", int'(eo[0]), 1);
      end
    end
    cyc(0, 0, 0, 0, 0, 0);
    #1 chk("wrap to 00", val(0), 0);

    // 24 h hours: ones wrap into tens and terminal wrap.
    cyc(0, 0, 0, 1, 1, 9);
    cyc(1, 0, 0, 0, 0, 0);
    #1 chk("u1 load 19", val(1), 19);
    chk("u2 reject 19", int'(le[2]), 1);
    cyc(0, 0, 0, 0, 0, 0);
    #1 chk("u1 19->20", val(1), 20);
    cyc(0, 0, 0, 1, 2, 3);
    cyc(1, 0, 0, 0, 0, 0);
    #1 chk("u1 23 enout", int'(eo[1]), 1);
    cyc(0, 0, 0, 0, 0, 0);
    #1 chk("u1 23->00", val(1), 0);

    // 12 h hours: rejected loads, then accepted 12 and wrap to 01.
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 1, 3);
    cyc(0, 0, 0, 0, 0, 0);
    #1 chk("u2 ld13 err", int'(le[2]), 1);
    chk("u2 ld13 unchanged", val(2), 1);
    cyc(0, 0, 0, 1, 0, 10);
    #1 chk("u2 err one cycle", int'(le[2]), 0);
    cyc(0, 0, 0, 1, 0, 0);
    #1 chk("u2 ld0A err", int'(le[2]), 1);
    cyc(0, 0, 0, 1, 1, 2);
    #1 chk("u2 ld00 err", int'(le[2]), 1);
    cyc(1, 0, 0, 0, 0, 0);
    #1 chk("u2 ld12 ok", val(2), 12);
    chk("u2 ld12 no err", int'(le[2]), 0);
    chk("u2 12 enout", int'(eo[2]), 1);
    cyc(0, 0, 0, 0, 0, 0);
    #1 chk("u2 12->01", val(2), 1);

    // adj and ld outrank enin and suppress the carry.
    cyc(0, 0, 0, 1, 5, 9);
    cyc(1, 0, 1, 0, 0, 0);
    #1 chk("adj+enin enout", int'(eo[0]), 0);
    cyc(0, 0, 0, 1, 5, 9);
    #1 chk("adj 59->00", val(0), 0);
    cyc(1, 0, 0, 1, 3, 0);
    #1 chk("ld+enin enout", int'(eo[0]), 0);
    cyc(0, 0, 0, 0, 0, 0);
    #1 chk("ld+enin value", val(0), 30);

    // Direction input: honoured only with the down-count feature.
    cyc(0, 0, 0, 1, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    #1 chk("dn at 00 enout", int'(eo[0]), DOWN ? 1 : 0);
    cyc(0, 0, 0, 1, 4, 0);
    #1 chk("dn from 00", val(0), DOWN ? 59 : 1);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    #1 chk("dn from 40", val(0), DOWN ? 39 : 41);

    // Reset wins over everything in the same cycle.
    cyc(0, 0, 0, 1, 3, 7);
    cyc(1, 0, 1, 1, 1, 2, 1, 0);
    #1 chk("rst enout", int'(eo[0]), 0);
    cyc(0, 0, 0, 0, 0, 0);
    #1 chk("rst value", val(0), 0);
    chk("rst ld_err", int'(le[3]), 0);

    // Randomised traffic, digits biased toward the legal ranges.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      rst  = ($urandom % 64) == 0;
      clr  = ($urandom % 64) == 0;
      ld   = ($urandom % 8) == 0;
      adj  = ($urandom % 8) == 0;
      enin = $urandom % 2;
      dn   = $urandom % 2;
      lt   = (($urandom % 4) == 0) ? 4'($urandom % 16) : 4'($urandom % 6);
      lo   = (($urandom % 4) == 0) ? 4'($urandom % 16) : 4'($urandom % 10);
    end
    cyc(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
